// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: instruction width, opcode constants, fetch entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 16;

    localparam logic [3:0] OP_NOOP  = 4'h0;
    localparam logic [3:0] OP_JUMP  = 4'hA;
    localparam logic [3:0] OP_CJUMP = 4'hC;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // One buffered fetch result: the instruction word and the PC it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: head instruction, its PC, valid/ready, halt.
// Latency: n/a (wires only).
// Backpressure: decoder holds out_ready low to stall; fetch keeps the head stable.
interface fetch_queue_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               out_ready;
    logic               halt_in;

    // master = fetch stage, slave = decoder
    modport master (
        output out_valid, out_instr, out_pc,
        input  out_ready, halt_in
    );

    modport slave (
        input  out_valid, out_instr, out_pc,
        output out_ready, halt_in
    );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush and occupancy count, head read straight from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
//   Ports: clk, rst_n (sync, active-low), push/push_dat, pop, flush, head_dat, count.
module sync_fifo #(
    parameter type T      = logic [7:0],
    parameter int  DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_dat,
    input  logic             pop,
    input  logic             flush,
    output T                 head_dat,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

        if (flush) begin
            // Storage is left alone; only the bookkeeping is cleared.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: issues ROM word reads, buffers {instr, pc} and feeds decode.
// Latency: request to out_valid is 2 cycles; one instruction per cycle sustained.
// Backpressure: requests issue only while buffered + in-flight < DEPTH, so pushes never overflow.
//   Ports: clk, rst_n (sync, active-low); imem_req/imem_addr/imem_rdata to the ROM;
//   dec (fetch_queue_if.master) to decode; redirect_valid/redirect_pc; halted status.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    fetch_queue_if.master      dec,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               halted
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic              halted_q, halted_d;

    logic [CNT_W-1:0]  occ;
    logic [CNT_W:0]    used;
    logic              credit_ok;
    logic              pop;
    logic              halt_pop;
    logic              push;
    logic              flush;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    always_comb begin
        // The in-flight slot counts against space before its data arrives.
        used       = {1'b0, occ} + (CNT_W + 1)'(inflight_q);
        credit_ok  = used < (CNT_W + 1)'(DEPTH);
        imem_req   = rst_n && !halted_q && !redirect_valid && credit_ok;
        imem_addr  = imem_req ? pc_q : '0;

        pop        = dec.out_valid && dec.out_ready;
        // A redirect in the same cycle overrides the halt.
        halt_pop   = pop && dec.halt_in && !redirect_valid;
        // Responses arriving during a flush, or after a halt, belong to a dead stream.
        push       = inflight_q && !redirect_valid && !halt_pop && !halted_q;
        flush      = redirect_valid || halt_pop;

        push_entry.instr = imem_rdata;
        push_entry.pc    = req_pc_q;

        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = imem_req;
        halted_d   = halted_q;

        if (imem_req) begin
            req_pc_d = pc_q;
        end
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            halted_d = 1'b0;
        end else begin
            if (imem_req) begin
                pc_d = pc_q + ADDR_W'(1);
            end
            if (halt_pop) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
        end
    end

    sync_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_entry),
        .count    (occ)
    );

    assign dec.out_valid = (occ != '0);
    assign dec.out_instr = head_entry.instr;
    assign dec.out_pc    = head_entry.pc;
    assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import cpu_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    fetch_queue_if #(.ADDR_W(ADDR_W)) dec_if ();

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .dec            (dec_if.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          d0;
    logic [15:0] nxt_pc;     // PC the decoder must see next
    logic [15:0] req_pc;     // address the next ROM request must use
    bit          halted_m;
    bit          flush_chk;
    bit          restart_chk;
    bit          halt5_en = 1'b0;
    bit          halt_rand_en = 1'b0;
    bit          filled;
    logic [15:0] req_log[$];
    logic [15:0] wrap_exp[4];

    // ROM contents: 16'h1000+addr, with halt words planted where enabled.
    function automatic logic [15:0] rom(input logic [15:0] a);
        if ((halt5_en && a == 16'd5) || (halt_rand_en && a[4:0] == 5'h13))
            return 16'h000F;
        return 16'h1000 + a;
    endfunction

    always @(posedge clk) begin
        imem_rdata <= imem_req ? rom(imem_addr) : 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: decoder reacts, everything is compared at the falling edge,
    // the model advances, and control returns just after the next rising edge.
    task automatic tick();
        logic [15:0] diff;
        @(negedge clk);
        dec_if.halt_in = dec_if.out_valid && (dec_if.out_instr == 16'h000F);
        if (!rst_n) begin
            nxt_pc      = '0;
            req_pc      = '0;
            halted_m    = 1'b0;
            flush_chk   = 1'b0;
            restart_chk = 1'b1;
        end else begin
            chk("halted", halted, halted_m);
            if (flush_chk) chk("flush_empty", dec_if.out_valid, 0);
            if (restart_chk && !redirect_valid) chk("restart_req", imem_req, 1);
            flush_chk   = 1'b0;
            restart_chk = 1'b0;
            if (halted_m) chk("halt_noreq", imem_req, 0);
            if (redirect_valid) chk("redir_noreq", imem_req, 0);
            if (imem_req) begin
                chk("req_addr", imem_addr, req_pc);
                diff = imem_addr - nxt_pc;
                chk("credit", {31'b0, diff < 16'(DEPTH)}, 1);
                req_log.push_back(imem_addr);
                req_pc++;
            end else begin
                chk("idle_addr", imem_addr, 0);
            end
            if (dec_if.out_valid && dec_if.out_ready) begin
                chk("pop_pc", dec_if.out_pc, nxt_pc);
                chk("pop_instr", dec_if.out_instr, rom(nxt_pc));
                nxt_pc++;
                delivered++;
                if (dec_if.halt_in && !redirect_valid) begin
                    halted_m  = 1'b1;
                    flush_chk = 1'b1;
                end
            end
            if (redirect_valid) begin
                nxt_pc      = redirect_pc;
                req_pc      = redirect_pc;
                halted_m    = 1'b0;
                flush_chk   = 1'b1;
                restart_chk = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", dec_if.out_valid, 0);
        chk("rst_instr", dec_if.out_instr, 0);
        chk("rst_pc", dec_if.out_pc, 0);
        chk("rst_halted", halted, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        dec_if.out_ready = 1'b0;
        dec_if.halt_in   = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;
        @(posedge clk); #1;
        tick();
        tick();
        chk_reset_outputs();

        // Reset release, streaming with decoder always ready.
        rst_n            = 1'b1;
        dec_if.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk("p1_valid", dec_if.out_valid, (c >= 2) ? 1 : 0);
            tick();
        end

        // Decoder stall: buffer fills to exactly DEPTH and fetch stops.
        dec_if.out_ready = 1'b0;
        repeat (10) tick();
        chk("stall_outstanding", 16'(req_pc - nxt_pc), DEPTH);
        chk("stall_req", imem_req, 0);
        chk("stall_valid", dec_if.out_valid, 1);
        dec_if.out_ready = 1'b1;
        d0 = delivered;
        repeat (12) tick();
        chk("drain_pops", delivered - d0, 12);

        // Redirect with three buffered and one in flight.
        dec_if.out_ready = 1'b0;
        filled = 1'b0;
        for (int i = 0; i < 20 && !filled; i++) begin
            tick();
            if (16'(req_pc - nxt_pc) == 16'(DEPTH)) filled = 1'b1;
        end
        chk("p3_fill", filled, 1);
        do_redirect(16'h0040);
        chk("p3_valid_low", dec_if.out_valid, 0);
        dec_if.out_ready = 1'b1;
        d0 = delivered;
        repeat (10) tick();
        chk("p3_pops", delivered - d0, 8);

        // Halt at pc 5, then restart with a redirect.
        halt5_en = 1'b1;
        do_redirect(16'h0000);
        for (int i = 0; i < 40 && !halted_m; i++) tick();
        chk("p4_halt_seen", halted_m, 1);
        repeat (6) tick();
        chk("p4_halted", halted, 1);
        chk("p4_valid", dec_if.out_valid, 0);
        halt5_en = 1'b0;
        do_redirect(16'h0000);
        d0 = delivered;
        repeat (10) tick();
        chk("p4_restart", halted, 0);
        chk("p4_pops", delivered - d0, 8);

        // PC wrap-around.
        do_redirect(16'hFFFE);
        req_log.delete();
        repeat (6) tick();
        for (int k = 0; k < 4; k++) chk("wrap_addr", req_log[k], wrap_exp[k]);

        // Randomized traffic: stalls, redirects, halts, occasional resets.
        halt_rand_en = 1'b1;
        do_redirect(16'h0000);
        d0 = delivered;
        for (int n = 0; n < 600; n++) begin
            dec_if.out_ready = ($urandom_range(0, 9) < 7);
            redirect_valid   = ($urandom_range(0, 19) == 0) ||
                               (halted_m && $urandom_range(0, 3) == 0);
            redirect_pc      = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                           : 16'($urandom_range(0, 255));
            rst_n            = !($urandom_range(0, 99) == 0);
            tick();
        end
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        chk("rand_progress", {31'b0, (delivered - d0) > 100}, 1);

        // Reset mid-stream with a full buffer.
        halt_rand_en = 1'b0;
        do_redirect(16'h0100);
        dec_if.out_ready = 1'b0;
        repeat (8) tick();
        chk("p7_full_valid", dec_if.out_valid, 1);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs();
        rst_n            = 1'b1;
        dec_if.out_ready = 1'b1;
        d0 = delivered;
        repeat (10) tick();
        chk("p7_pops", delivered - d0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Generates word addresses into a synchronous instruction ROM and buffers returned 16-bit instructions with their PCs in a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake.
- Supports a redirect (jump/branch resolution) that flushes buffered and in-flight fetches, and stops fetching once decode consumes a halt.

Parameters:
- ADDR_W, 16, PC / instruction-memory word-address width.
- DEPTH, 4, instruction buffer entries (power of two, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  read request to instruction ROM this cycle.
- imem_addr  out  ADDR_W  word address of the request.
- imem_rdata  in  16  ROM data; valid exactly one cycle after imem_req.
- out_valid  out  1  FIFO head holds a valid instruction.
- out_instr  out  16  head instruction (to decoder instr).
- out_pc  out  ADDR_W  PC of head instruction.
- out_ready  in  1  decoder accepts head this cycle.
- halt_in  in  1  decoder's halt output for the head instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch PC.
- halted  out  1  fetch stopped by a consumed halt.

Behaviour:
- Reset (rst_n=0 at an edge): pc=0, FIFO empty, in-flight flag=0, halted=0.
  - Outputs during/after reset: out_valid=0, out_instr=0, out_pc=0, imem_req=0, imem_addr=0.
- Credit rule: imem_req = !halted && !redirect_valid && (occupancy + inflight < DEPTH).
  - imem_req is combinational; imem_addr = pc whenever imem_req=1, else 0.
  - On a request: pc <= pc+1, wrapping modulo 2^ADDR_W; inflight <= 1 with the request's pc captured.
- Response: the cycle after a request, if not killed, push {imem_rdata, captured pc}.
  - Credit guarantees space, so a push never overflows, including a simultaneous pop.
- Occupancy counter width is $clog2(DEPTH+1). Push and pop in the same cycle leave occupancy unchanged.
- Throughput: one instruction per cycle steady state.
  - First request is issued in the first cycle with rst_n=1, at addr 0.
  - out_valid rises 2 cycles after that request.
- Pop occurs when out_valid && out_ready. out_instr/out_pc are driven from FIFO storage and are stable while out_valid && !out_ready.
- Halt: pop with halt_in=1 sets halted=1.
  - The remaining FIFO is flushed and any in-flight response discarded.
  - No further requests until redirect or reset. halt_in is ignored without a pop.
- Redirect (redirect_valid=1):
  - FIFO flushed; an in-flight response in the next cycle is discarded.
  - pc <= redirect_pc; halted <= 0; no request this cycle.
  - out_valid=0 from the next cycle; the first request at redirect_pc is issued the following cycle.
- Redirect simultaneous with halt pop: redirect wins; halted stays 0.
- Redirect simultaneous with a pop: the pop completes (decoder took the head), then the flush.
- Reset mid-operation: all state returns to reset values; in-flight data is discarded.
- Empty: out_valid=0, out_instr/out_pc hold last head value (don't-care).

Decomposition:
- Shared package cpu_pkg holds:
  - INSTR_W=16;
  - opcode constants OP_NOOP=4'h0 … OP_JUMP=4'hA, OP_CJUMP=4'hC, OP_HALT=4'hF;
  - typedef fetch_entry_t {logic[INSTR_W-1:0] instr; logic[ADDR_W-1:0] pc;}.
- One sub-module, sync_fifo (parameterised entry type/depth, push/pop/flush, count out).
- PC, credit and kill logic stay in fetch_queue.

Test Plan:
- Reset release, ROM[i]=16'h1000+i, out_ready=1 → imem_addr 0,1,2,… one per cycle; out_instr 16'h1000, 16'h1001… back-to-back with out_pc 0,1,2.
- out_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, occupancy 4, imem_req=0. Release out_ready → entries 0..3 in order, fetching resumes at addr 4 with no gap or duplicate.
- Redirect to 16'h0040 while FIFO holds 3 entries and one request is in flight → out_valid=0 next cycle, stale data never appears. Next accepted instruction has out_pc=16'h0040.
- ROM[5]=16'h000F (halt opcode), decoder halt_in driven on it → pop at pc 5 sets halted=1, out_valid=0, no imem_req afterwards. A later redirect to 0 restarts fetch.
- pc = 16'hFFFE with no stalls → addresses FFFE, FFFF, 0000, 0001.
- rst_n=0 for one cycle mid-stream with full FIFO → all outputs zero; first post-reset request at addr 0; no pre-reset instruction delivered.
